// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: operation encodings, FSM states
// and the default stack depth.
package stack_pkg;

  localparam int STACK_DEPTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RWAIT,
    ST_DONE
  } state_e;

  function automatic logic is_write_op(op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Core request/response, stack-pointer strobes and stack RAM port of stack_seq.
// err exists only when STACK_SEQ_BOUNDS_EN is defined.
interface stack_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic [15:0] req_pc;
  logic        sp_push;
  logic        sp_pop;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        pc_load;
  logic [15:0] pc_value;
`ifdef STACK_SEQ_BOUNDS_EN
  logic        err;
`endif

  modport slave (
`ifdef STACK_SEQ_BOUNDS_EN
    output err,
`endif
    input  req_valid, req_op, req_data, req_pc, mem_rdata,
    output req_ready, sp_push, sp_pop, mem_we, mem_re, mem_wdata,
    output rsp_valid, rsp_data, pc_load, pc_value
  );

  modport master (
`ifdef STACK_SEQ_BOUNDS_EN
    input  err,
`endif
    output req_valid, req_op, req_data, req_pc, mem_rdata,
    input  req_ready, sp_push, sp_pop, mem_we, mem_re, mem_wdata,
    input  rsp_valid, rsp_data, pc_load, pc_value
  );

endinterface

// File: rtl/stack_seq.sv
// Stack operation sequencer: turns PUSH/POP/CALL/RET requests into SP and RAM strobes.
// Define STACK_SEQ_BOUNDS_EN to add the depth counter and over/underflow err pulse.
module stack_seq
  import stack_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  stack_seq_if.slave bus
);

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("stack_seq: STACK_DEPTH must be at least 1");
  end

  state_e      state_reg, state_next;
  op_e         op_reg;
  logic [15:0] data_reg;
  logic [15:0] mem_wdata_reg;
  logic [15:0] rsp_data_reg;
  logic [15:0] pc_value_reg;
  logic        accept;
  logic        reject_now;
  logic        reject_reg;
  op_e         req_op_in;

  assign req_op_in = op_e'(bus.req_op);
  assign accept    = bus.req_valid && (state_reg == ST_IDLE);

`ifdef STACK_SEQ_BOUNDS_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  logic [DW-1:0] depth_reg;

  assign reject_now = is_write_op(req_op_in) ? (depth_reg == DEPTH_MAX)
                                             : (depth_reg == '0);

  // Depth moves at acceptance so a back-to-back request sees the updated count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_reg  <= '0;
      reject_reg <= 1'b0;
    end else if (accept) begin
      reject_reg <= reject_now;
      if (!reject_now) begin
        depth_reg <= is_write_op(req_op_in) ? depth_reg + DW'(1) : depth_reg - DW'(1);
      end
    end
  end
`else
  assign reject_now = 1'b0;
  assign reject_reg = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.req_ready = 1'b0;
    bus.sp_push   = 1'b0;
    bus.sp_pop    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.pc_load   = 1'b0;
`ifdef STACK_SEQ_BOUNDS_EN
    bus.err       = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (reject_now) begin
            state_next = ST_DONE;
          end else if (is_write_op(req_op_in)) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        bus.sp_push = 1'b1;
        bus.mem_we  = 1'b1;
        state_next  = ST_DONE;
      end
      ST_READ: begin
        bus.sp_pop = 1'b1;
        bus.mem_re = 1'b1;
        state_next = ST_RWAIT;
      end
      ST_RWAIT: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.rsp_valid = 1'b1;
        bus.pc_load   = ((op_reg == OP_CALL) || (op_reg == OP_RET)) && !reject_reg;
`ifdef STACK_SEQ_BOUNDS_EN
        bus.err       = reject_reg;
`endif
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // rsp_data is cleared on acceptance so non-popping operations report zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg        <= OP_PUSH;
      data_reg      <= '0;
      mem_wdata_reg <= '0;
      rsp_data_reg  <= '0;
      pc_value_reg  <= '0;
    end else begin
      if (accept) begin
        op_reg       <= req_op_in;
        data_reg     <= bus.req_data;
        rsp_data_reg <= '0;
        if (!reject_now && is_write_op(req_op_in)) begin
          mem_wdata_reg <= (req_op_in == OP_CALL) ? bus.req_pc : bus.req_data;
        end
      end
      if (state_reg == ST_WRITE && op_reg == OP_CALL) begin
        pc_value_reg <= data_reg;
      end
      if (state_reg == ST_RWAIT) begin
        rsp_data_reg <= bus.mem_rdata;
        if (op_reg == OP_RET) begin
          pc_value_reg <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.pc_value  = pc_value_reg;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: vector table of single operations plus reset,
// back-to-back and (with STACK_SEQ_BOUNDS_EN) over/underflow sequences.
module tb_stack_seq;
  import stack_pkg::*;

`ifdef STACK_SEQ_BOUNDS_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 256;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] cur_ram = 16'h0000;
  int checks = 0;
  int errors = 0;

  stack_seq_if bus ();

  stack_seq #(.STACK_DEPTH(TB_DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM stand-in: returns the vector's word one cycle after mem_re.
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_re ? cur_ram : 16'hDEAD;
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] pc;
    logic [15:0] ram;
    logic [15:0] exp_wdata;
    logic [15:0] exp_rsp;
    logic        exp_pcl;
    logic [15:0] exp_pcv;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [15:0] data,
                       input logic [15:0] pc, input logic [15:0] ram,
                       input logic [15:0] exp_wdata, input logic [15:0] exp_rsp,
                       input logic exp_pcl, input logic [15:0] exp_pcv, input logic exp_rej);
    int n_push = 0, n_pop = 0, n_we = 0, n_re = 0, n_rsp = 0, clash = 0;
    int push_c = 0, pop_c = 0, rsp_c = 0, rdy_done = 1, err_seen = 0;
    logic [15:0] wd = 0, rd = 0, pcv = 0;
    logic pcl = 0;
    int exp_lat;
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    chk({name, " ready"}, bus.req_ready, 1);
    cur_ram       = ram;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    bus.req_pc    = pc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = op ^ 2'b01;
    bus.req_data  = data ^ 16'hBEEF;
    bus.req_pc    = ~pc;
    for (int c = 1; c <= 5; c++) begin
      if (bus.sp_push) begin n_push++; push_c = c; wd = bus.mem_wdata; end
      if (bus.sp_pop)  begin n_pop++;  pop_c = c; end
      if (bus.mem_we)  n_we++;
      if (bus.mem_re)  n_re++;
      if ((bus.sp_push && bus.sp_pop) || (bus.mem_we && bus.mem_re)) clash++;
      if (bus.rsp_valid) begin
        n_rsp++; rsp_c = c; rd = bus.rsp_data; pcl = bus.pc_load;
        pcv = bus.pc_value; rdy_done = bus.req_ready;
`ifdef STACK_SEQ_BOUNDS_EN
        err_seen = bus.err;
`endif
      end
      @(posedge clk); #1;
    end
    exp_lat = exp_rej ? 1 : (op[0] ? 3 : 2);
    chk({name, " rsp_count"}, n_rsp, 1);
    chk({name, " latency"}, rsp_c, exp_lat);
    chk({name, " rsp_data"}, rd, exp_rsp);
    chk({name, " pc_load"}, pcl, exp_pcl);
    if (exp_pcl) chk({name, " pc_value"}, pcv, exp_pcv);
    chk({name, " ready_in_done"}, rdy_done, 0);
    chk({name, " strobe_clash"}, clash, 0);
`ifdef STACK_SEQ_BOUNDS_EN
    chk({name, " err"}, err_seen, exp_rej);
`endif
    if (exp_rej) begin
      chk({name, " no_strobes"}, n_push + n_pop + n_we + n_re, 0);
    end else if (!op[0]) begin
      chk({name, " push_strobes"}, {n_push[7:0], n_we[7:0], push_c[7:0]}, 24'h010101);
      chk({name, " mem_wdata"}, wd, exp_wdata);
      chk({name, " no_pop"}, n_pop + n_re, 0);
    end else begin
      chk({name, " pop_strobes"}, {n_pop[7:0], n_re[7:0], pop_c[7:0]}, 24'h010101);
      chk({name, " no_push"}, n_push + n_we, 0);
    end
    $display("op %s: lat=%0d rsp_data=%h pc_load=%0d pc_value=%h", name, rsp_c, rd, pcl, pcv);
  endtask

  initial begin
    int stray;
    vecs[0] = '{2'b00, 16'hA5A5, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{2'b01, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 1'b0, 16'h0000};
    vecs[2] = '{2'b10, 16'h0200, 16'h0105, 16'h0000, 16'h0105, 16'h0000, 1'b1, 16'h0200};
    vecs[3] = '{2'b11, 16'h0000, 16'h0000, 16'h0105, 16'h0000, 16'h0105, 1'b1, 16'h0105};
    vecs[4] = '{2'b00, 16'h5A5A, 16'h0333, 16'h0000, 16'h5A5A, 16'h0000, 1'b0, 16'h0000};
    vecs[5] = '{2'b01, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 16'h0000};
    vecs[6] = '{2'b10, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 16'h0000};
    vecs[7] = '{2'b11, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 16'h8001, 1'b1, 16'h8001};

    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_data  = 16'h0000;
    bus.req_pc    = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", bus.req_ready, 1);
    chk("reset strobes", {bus.sp_push, bus.sp_pop, bus.mem_we, bus.mem_re, bus.rsp_valid, bus.pc_load}, 0);
    chk("reset data", {bus.mem_wdata, bus.rsp_data, bus.pc_value}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].pc, vecs[i].ram,
            vecs[i].exp_wdata, vecs[i].exp_rsp, vecs[i].exp_pcl, vecs[i].exp_pcv, 1'b0);
    end

    // Request held through DONE must wait for IDLE before being taken.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_data = 16'h1111;
    @(posedge clk); #1;
    chk("b2b first wdata", bus.mem_wdata, 16'h1111);
    bus.req_data = 16'h2222;
    @(posedge clk); #1;
    chk("b2b done rsp", bus.rsp_valid, 1);
    chk("b2b done ready", bus.req_ready, 0);
    @(posedge clk); #1;
    chk("b2b idle ready", bus.req_ready, 1);
    chk("b2b idle push", bus.sp_push, 0);
    @(posedge clk); #1;
    chk("b2b second push", bus.sp_push, 1);
    chk("b2b second wdata", bus.mem_wdata, 16'h2222);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b second rsp", bus.rsp_valid, 1);
    $display("seq back_to_back: done");

    do_op("pop2222", 2'b01, 16'h0, 16'h0, 16'h2222, 16'h0, 16'h2222, 1'b0, 16'h0, 1'b0);

    // Reset asserted in RWAIT aborts the RET.
    @(negedge clk);
    cur_ram = 16'h4321;
    bus.req_valid = 1'b1; bus.req_op = 2'b11;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst read strobe", bus.sp_pop, 1);
    @(posedge clk); #1;
    chk("rst rwait ready", bus.req_ready, 0);
    reset = 1'b1;
    #1;
    chk("rst immediate ready", bus.req_ready, 1);
    chk("rst immediate outputs", {bus.rsp_valid, bus.pc_load, bus.pc_value, bus.rsp_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || bus.pc_load || bus.sp_push || bus.sp_pop || bus.mem_we || bus.mem_re) stray++;
    end
    chk("rst no activity", stray, 0);
    $display("seq reset_in_rwait: stray=%0d", stray);

`ifdef STACK_SEQ_BOUNDS_EN
    do_op("underflow", 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    do_op("push1", 2'b00, 16'hC001, 16'h0, 16'h0, 16'hC001, 16'h0, 1'b0, 16'h0, 1'b0);
    do_op("push2", 2'b00, 16'hC002, 16'h0, 16'h0, 16'hC002, 16'h0, 1'b0, 16'h0, 1'b0);
    do_op("overflow", 2'b00, 16'hC003, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    do_op("pop_after", 2'b01, 16'h0, 16'h0, 16'hC002, 16'h0, 16'hC002, 1'b0, 16'h0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 Parameter: STACK_DEPTH, default 256, maximum number of 16-bit words held on the stack.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  core requests a stack operation.
REQ-005 req_ready  out  1  sequencer is in IDLE and accepts a request.
REQ-006 req_op  in  2  operation: 00 PUSH, 01 POP, 10 CALL, 11 RET.
REQ-007 req_data  in  16  PUSH operand or CALL target address.
REQ-008 req_pc  in  16  return address pushed by CALL.
REQ-009 sp_push  out  1  one-cycle strobe to the stack pointer: address = SP-1, then decrement.
REQ-010 sp_pop  out  1  one-cycle strobe to the stack pointer: address = SP, then increment.
REQ-011 mem_we  out  1  stack memory write strobe.
REQ-012 mem_re  out  1  stack memory read strobe.
REQ-013 mem_wdata  out  16  write data to stack memory.
REQ-014 mem_rdata  in  16  read data, valid one cycle after mem_re (synchronous RAM).
REQ-015 rsp_valid  out  1  one-cycle pulse: operation complete.
REQ-016 rsp_data  out  16  popped word (POP/RET); zero otherwise.
REQ-017 pc_load  out  1  one-cycle strobe: core loads pc_value into PC.
REQ-018 pc_value  out  16  new PC for CALL/RET.

Function
REQ-019 FSM states: IDLE, WRITE, READ, RWAIT, DONE; encoding is free.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a clock edge.
REQ-021 On acceptance, req_op, req_data and req_pc SHALL be registered; later changes on the inputs SHALL be ignored.
REQ-022 PUSH/CALL SHALL go IDLE->WRITE->DONE->IDLE.
REQ-023 In WRITE, sp_push and mem_we SHALL both be 1 for exactly one cycle; mem_wdata = req_data (PUSH) or req_pc (CALL).
REQ-024 POP/RET SHALL go IDLE->READ->RWAIT->DONE->IDLE.
REQ-025 In READ, sp_pop and mem_re SHALL both be 1 for exactly one cycle.
REQ-026 In RWAIT, mem_rdata SHALL be captured into rsp_data.
REQ-027 In DONE, rsp_valid SHALL pulse for exactly one cycle.
REQ-028 In DONE, pc_load SHALL be 1 for CALL (pc_value = captured req_data) and for RET (pc_value = popped word).
REQ-029 Latency from acceptance to rsp_valid: 2 cycles for PUSH/CALL; 3 cycles for POP/RET.
REQ-030 sp_push and sp_pop SHALL never be 1 in the same cycle.
REQ-031 mem_we and mem_re SHALL never be 1 in the same cycle.
REQ-032 Outside the states above, all strobes SHALL be 0; mem_wdata and pc_value SHALL hold their last value.
REQ-033 req_valid in DONE SHALL NOT be accepted; it is accepted in IDLE the following cycle.

Reset
REQ-034 While reset is 1, the FSM SHALL be IDLE and all outputs 0, except req_ready, which SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL abort the operation: no further strobes, no rsp_valid, no pc_load.

Configuration
REQ-036 With STACK_SEQ_BOUNDS_EN defined:
- Add output err (1 bit) and an internal depth counter, 0..STACK_DEPTH.
- Depth increments on PUSH/CALL and decrements on POP/RET.
- PUSH/CALL at depth==STACK_DEPTH, or POP/RET at depth==0, SHALL go IDLE->DONE directly.
- Such a rejected operation issues no sp_*, mem_* or pc_load strobe; rsp_valid and err pulse together.
- Reset clears depth to 0.
REQ-037 Without STACK_SEQ_BOUNDS_EN, there is no err port and no depth counter; over/underflow is not detected.

Structure
REQ-038 Shared package stack_pkg SHALL hold the req_op encodings, the FSM state type and STACK_DEPTH default.
REQ-039 Single module, no sub-modules; the external stack pointer and RAM are instantiated by the parent.

Verification
REQ-040 PUSH 16'hA5A5 -> cycle+1: sp_push=mem_we=1, mem_wdata=A5A5; cycle+2: rsp_valid=1, pc_load=0.
REQ-041 POP with RAM returning 16'h1234 -> cycle+1: sp_pop=mem_re=1; cycle+3: rsp_valid=1, rsp_data=1234.
REQ-042 CALL req_data=0x0200, req_pc=0x0105 -> mem_wdata=0105 with sp_push; then pc_load=1, pc_value=0200.
REQ-043 RET with RAM returning 0x0105 -> pc_load=1, pc_value=0105, rsp_data=0105 on the rsp_valid cycle.
REQ-044 Reset asserted in RWAIT -> req_ready=1 immediately; no rsp_valid or pc_load afterwards.
REQ-045 BOUNDS_EN, STACK_DEPTH=2: three PUSHes -> third gets err=1 with no sp_push; a POP at depth 0 gets err=1.
